// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module     : uart_rx_deser
// Description: UART receive front end. Synchronises rx, samples 8N1 frames at
//              mid-bit and pushes good bytes to the rx FIFO. Define
//              UART_RX_PARITY_EN for 8E1 frames with parity checking.
// Revision   : 1.0 - initial release
// ============================================================================
module uart_rx_deser #(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [CNT_W-1:0]  clk_div,
    input  logic              rx,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_push,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err,
    output logic              busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_MIN_DIV  = CNT_W'(4);
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_W - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4,
        S_PARITY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
    } state_t;
`endif

    state_t            r_state;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic              r_rx_prev;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
`ifdef UART_RX_PARITY_EN
    logic              r_par_bad;
`endif

    logic              w_fall;
    logic [CNT_W-1:0]  w_div_in;
    logic [CNT_W-1:0]  w_half_m1;
    logic [CNT_W-1:0]  w_div_m1;
    logic              w_par_bad;

    assign w_fall    = r_rx_prev & ~r_rx_s;
    assign w_div_in  = (clk_div < C_MIN_DIV) ? C_MIN_DIV : clk_div;
    assign w_half_m1 = (r_div >> 1) - CNT_W'(1);
    assign w_div_m1  = r_div - CNT_W'(1);
`ifdef UART_RX_PARITY_EN
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Synchroniser idles high so reset never fakes a start edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div      <= C_MIN_DIV;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            rx_data    <= '0;
            rx_push    <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_push    <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_div   <= w_div_in;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == w_half_m1) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == w_div_m1) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == w_div_m1) begin
                        r_cnt     <= '0;
                        r_par_bad <= r_rx_s ^ (^r_shift);
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == w_div_m1) begin
                        r_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_err <= r_par_bad;
`endif
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            if (!w_par_bad) begin
                                if (fifo_full) begin
                                    overrun <= 1'b1;
                                end else begin
                                    rx_data <= r_shift;
                                    rx_push <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    // Line must return high before a new start edge is accepted.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module     : tb_uart_rx_deser
// Description: Directed self-checking bench for uart_rx_deser.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deser;

    localparam int CNT_W  = 16;
    localparam int DATA_W = 8;
`ifdef UART_RX_PARITY_EN
    localparam int C_LAT16 = 171;
`else
    localparam int C_LAT16 = 155;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] clk_div = 16'd16;
    logic             rx = 1'b1;
    logic             fifo_full = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_push, frame_err, overrun, parity_err, busy;

    int vectors = 0, miscompares = 0;
    int cyc = 0, n_push = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_busy = 0;
    int last_push_cyc = 0;
    int bitlen = 16;
    logic [7:0] last_good = 8'h00;
    logic [7:0] pushed[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_deser #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .clk_div(clk_div), .rx(rx),
        .fifo_full(fifo_full), .rx_data(rx_data), .rx_push(rx_push),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_push) begin
            n_push++;
            last_push_cyc = cyc;
            pushed.push_back(rx_data);
        end
        if (frame_err)  n_ferr++;
        if (overrun)    n_ovr++;
        if (parity_err) n_perr++;
        if (busy)       n_busy++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic set_div(input int d);
        clk_div = CNT_W'(d);
        bitlen  = (d < 4) ? 4 : d;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (bitlen) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_b);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (rx_push !== 1'b0) begin miscompares++; $display("FAIL reset_push: got %b expected 0", rx_push); end
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        int p0, f0, o0, t0, lat;
        set_div(16);
        p0 = n_push; f0 = n_ferr; o0 = n_ovr;
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        lat = last_push_cyc - t0;
        vectors++; if (n_push - p0 !== 1) begin miscompares++; $display("FAIL basic_pushes: got %0d expected 1", n_push - p0); end
        vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL basic_data: got %h expected a5", rx_data); end
        vectors++; if (lat < C_LAT16 - 2 || lat > C_LAT16 + 2) begin miscompares++; $display("FAIL basic_latency: got %0d expected %0d", lat, C_LAT16); end
        vectors++; if (n_ferr - f0 + n_ovr - o0 !== 0) begin miscompares++; $display("FAIL basic_flags: got %0d expected 0", n_ferr - f0 + n_ovr - o0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
        last_good = 8'hA5;
    endtask

    task automatic test_patterns();
        int divs[5] = '{16, 16, 2, 7, 4};
        logic [7:0] bytes[5] = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h96};
        for (int i = 0; i < 5; i++) begin
            int p0;
            set_div(divs[i]);
            p0 = n_push;
            send_frame(bytes[i], 1'b1);
            repeat (8) @(negedge clk);
            vectors++; if (n_push - p0 !== 1) begin miscompares++; $display("FAIL pattern%0d_pushes: got %0d expected 1", i, n_push - p0); end
            vectors++; if (rx_data !== bytes[i]) begin miscompares++; $display("FAIL pattern%0d_data: got %h expected %h", i, rx_data, bytes[i]); end
            last_good = bytes[i];
        end
        set_div(16);
    endtask

    task automatic test_glitch();
        int p0, f0, b0, bc;
        p0 = n_push; f0 = n_ferr; b0 = n_busy;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        bc = n_busy - b0;
        vectors++; if (bc < 6 || bc > 10) begin miscompares++; $display("FAIL glitch_busy_cycles: got %0d expected 8", bc); end
        vectors++; if (n_push - p0 + n_ferr - f0 !== 0) begin miscompares++; $display("FAIL glitch_events: got %0d expected 0", n_push - p0 + n_ferr - f0); end
    endtask

    task automatic test_frame_err();
        int p0, f0;
        p0 = n_push; f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i[2] ^ i[1] ? 1'b1 : 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        vectors++; if (n_ferr - f0 !== 1) begin miscompares++; $display("FAIL ferr_pulses: got %0d expected 1", n_ferr - f0); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_low: got %b expected 1", busy); end
        rx = 1'b1;
        repeat (6) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_busy_high: got %b expected 0", busy); end
        vectors++; if (n_push - p0 !== 0) begin miscompares++; $display("FAIL ferr_pushes: got %0d expected 0", n_push - p0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_overrun();
        int p0, o0;
        p0 = n_push; o0 = n_ovr;
        fifo_full = 1'b1;
        send_frame(8'h81, 1'b1);
        fifo_full = 1'b0;
        repeat (30) @(negedge clk);
        vectors++; if (n_ovr - o0 !== 1) begin miscompares++; $display("FAIL ovr_pulses: got %0d expected 1", n_ovr - o0); end
        vectors++; if (n_push - p0 !== 0) begin miscompares++; $display("FAIL ovr_pushes: got %0d expected 0", n_push - p0); end
        vectors++; if (rx_data !== last_good) begin miscompares++; $display("FAIL ovr_data_held: got %h expected %h", rx_data, last_good); end
    endtask

    task automatic test_back_to_back();
        int s0;
        logic [7:0] exp[3] = '{8'h11, 8'h22, 8'h33};
        s0 = pushed.size();
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
        repeat (10) @(negedge clk);
        vectors++;
        if (pushed.size() - s0 !== 3) begin
            miscompares++; $display("FAIL b2b_pushes: got %0d expected 3", pushed.size() - s0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++; if (pushed[s0 + i] !== exp[i]) begin miscompares++; $display("FAIL b2b_data%0d: got %h expected %h", i, pushed[s0 + i], exp[i]); end
            end
        end
        last_good = 8'h33;
    endtask

    task automatic test_reset_midframe();
        int s0, f0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        repeat (20) @(negedge clk);
        s0 = pushed.size(); f0 = n_ferr;
        send_frame(8'h12, 1'b1);
        repeat (10) @(negedge clk);
        vectors++;
        if (pushed.size() - s0 !== 1) begin
            miscompares++; $display("FAIL rstmid_pushes: got %0d expected 1", pushed.size() - s0);
        end else begin
            vectors++; if (pushed[s0] !== 8'h12) begin miscompares++; $display("FAIL rstmid_data: got %h expected 12", pushed[s0]); end
        end
        vectors++; if (n_ferr - f0 !== 0) begin miscompares++; $display("FAIL rstmid_ferr: got %0d expected 0", n_ferr - f0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int p0, e0;
        p0 = n_push; e0 = n_perr;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        repeat (10) @(negedge clk);
        vectors++; if (n_perr - e0 !== 1) begin miscompares++; $display("FAIL par_bad_pulses: got %0d expected 1", n_perr - e0); end
        vectors++; if (n_push - p0 !== 0) begin miscompares++; $display("FAIL par_bad_pushes: got %0d expected 0", n_push - p0); end
        par_flip = 1'b0;
        p0 = n_push; e0 = n_perr;
        send_frame(8'h07, 1'b1);
        repeat (10) @(negedge clk);
        vectors++; if (n_push - p0 !== 1) begin miscompares++; $display("FAIL par_good_pushes: got %0d expected 1", n_push - p0); end
        vectors++; if (rx_data !== 8'h07) begin miscompares++; $display("FAIL par_good_data: got %h expected 07", rx_data); end
        vectors++; if (n_perr - e0 !== 0) begin miscompares++; $display("FAIL par_good_perr: got %0d expected 0", n_perr - e0); end
    endtask
`else
    task automatic test_parity();
        vectors++; if (n_perr !== 0) begin miscompares++; $display("FAIL parity_tied: got %0d expected 0", n_perr); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
